// File: rtl/if_stage_unit_pkg.sv
// Shared fetch-stage encodings: next-PC select codes, the NOP word and the jump-target helper.
package if_stage_unit_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'b00,
    PC_SRC_BR  = 2'b01,
    PC_SRC_J   = 2'b10,
    PC_SRC_JR  = 2'b11
  } pc_src_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  // J/JAL target: region bits come from the delay-slot PC held in IF/ID.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on inc_i and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_stage_unit.sv
// Fetch stage: PC register, next-PC select, IF/ID register with stall/flush handling,
// plus saturating stall and flush event counters.
module if_stage_unit
  import if_stage_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic             flush,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      branch_target,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_data,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0] pc_q, pc_d, pc4;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        valid_q, valid_d;
  logic        flush_fire;

  assign pc4        = pc_q + 32'd4;
  assign flush_fire = pc_write && flush;

  // Redirect select only matters on a flush; otherwise fetch runs sequentially.
  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = pc4;
      if (flush) begin
        unique case (pc_src_e'(pc_src))
          PC_SRC_SEQ: pc_d = pc4;
          PC_SRC_BR:  pc_d = branch_target;
          PC_SRC_J:   pc_d = jump_target(ifid_pc4_q, jump_index);
          PC_SRC_JR:  pc_d = jr_target;
          default:    pc_d = pc4;
        endcase
      end
    end
  end

  // A stall wins over flush: the stalled branch in ID has not resolved yet.
  always_comb begin
    inst_d     = inst_q;
    ifid_pc4_d = ifid_pc4_q;
    valid_d    = valid_q;
    if (!pc_write) begin
      inst_d = inst_q;
    end else if (flush) begin
      inst_d     = NOP_INST;
      ifid_pc4_d = pc4;
      valid_d    = 1'b0;
    end else if (IF_ID_write) begin
      inst_d     = inst_data;
      ifid_pc4_d = pc4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      ifid_pc4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ifid_pc4_q <= ifid_pc4_d;
      valid_q    <= valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (!pc_write),
    .count_o (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (flush_fire),
    .count_o (flush_count)
  );

  assign inst_addr   = pc_q;
  assign IF_ID_inst  = inst_q;
  assign IF_ID_pc4   = ifid_pc4_q;
  assign IF_ID_valid = valid_q;

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed bench for if_stage_unit: sequential fetch, stalls, flush redirects, wrap,
// counter saturation and asynchronous reset.
module tb_if_stage_unit;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] INST  = 32'h2008_0005;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_write, IF_ID_write, flush;
  logic [1:0]       pc_src;
  logic [31:0]      branch_target, jr_target, inst_data;
  logic [25:0]      jump_index;
  logic [31:0]      inst_addr, IF_ID_inst, IF_ID_pc4;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage_unit #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .IF_ID_write   (IF_ID_write),
    .flush         (flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .inst_addr     (inst_addr),
    .inst_data     (inst_data),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc4     (IF_ID_pc4),
    .IF_ID_valid   (IF_ID_valid),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0; pc_src = 2'b00;
    branch_target = '0; jr_target = '0; jump_index = '0; inst_data = INST;
    #1;
    chk("rst_pc",    inst_addr, 32'h0);
    chk("rst_inst",  IF_ID_inst, NOP);
    chk("rst_pc4",   IF_ID_pc4, 32'h0);
    chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_flush", {16'd0, flush_count}, 32'd0);
    #11 rst = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("seq_pc%0d", i), inst_addr, 32'(4 * i));
      chk($sformatf("seq_pc4_%0d", i), IF_ID_pc4, 32'(4 * i));
    end
    chk("seq_inst",  IF_ID_inst, INST);
    chk("seq_valid", {31'd0, IF_ID_valid}, 32'd1);

    pc_write = 1'b0; IF_ID_write = 1'b0; inst_data = 32'hDEAD_BEEF;
    step(); step();
    chk("stall_pc",    inst_addr, 32'h10);
    chk("stall_inst",  IF_ID_inst, INST);
    chk("stall_pc4",   IF_ID_pc4, 32'h10);
    chk("stall_cnt",   {16'd0, stall_count}, 32'd2);

    pc_write = 1'b1; IF_ID_write = 1'b1; inst_data = INST;
    for (int i = 0; i < 4; i++) step();
    chk("resume_pc", inst_addr, 32'h20);

    flush = 1'b1; pc_src = 2'b01; branch_target = 32'h100;
    step();
    chk("br_pc",    inst_addr, 32'h100);
    chk("br_inst",  IF_ID_inst, NOP);
    chk("br_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("br_pc4",   IF_ID_pc4, 32'h24);
    chk("br_fcnt",  {16'd0, flush_count}, 32'd1);

    pc_src = 2'b11; jr_target = 32'h4000_0004;
    step();
    flush = 1'b0;
    step();
    chk("pre_j_pc4", IF_ID_pc4, 32'h4000_0008);
    chk("pre_j_val", {31'd0, IF_ID_valid}, 32'd1);

    flush = 1'b1; pc_src = 2'b10; jump_index = 26'h40;
    step();
    chk("j_pc",   inst_addr, 32'h4000_0100);
    chk("j_fcnt", {16'd0, flush_count}, 32'd3);

    pc_src = 2'b11; jr_target = 32'h80;
    step();
    chk("jr_pc", inst_addr, 32'h80);

    flush = 1'b0; pc_src = 2'b01; branch_target = 32'h500;
    step();
    chk("nof_pc", inst_addr, 32'h84);
    chk("nof_pc4", IF_ID_pc4, 32'h84);

    flush = 1'b1; pc_write = 1'b0; IF_ID_write = 1'b1; inst_data = 32'h1234_5678;
    step();
    chk("sf_pc",    inst_addr, 32'h84);
    chk("sf_inst",  IF_ID_inst, INST);
    chk("sf_pc4",   IF_ID_pc4, 32'h84);
    chk("sf_valid", {31'd0, IF_ID_valid}, 32'd1);
    chk("sf_fcnt",  {16'd0, flush_count}, 32'd4);
    chk("sf_scnt",  {16'd0, stall_count}, 32'd3);

    pc_write = 1'b1; pc_src = 2'b11; jr_target = 32'hFFFF_FFFC; inst_data = INST;
    step();
    flush = 1'b0;
    step();
    chk("wrap_pc",  inst_addr, 32'h0);
    chk("wrap_pc4", IF_ID_pc4, 32'h0);

    pc_write = 1'b0;
    for (int i = 0; i < 65532; i++) step();
    chk("sat_reach", {16'd0, stall_count}, 32'h0000_FFFF);
    step();
    chk("sat_hold",  {16'd0, stall_count}, 32'h0000_FFFF);

    rst = 1'b0;
    #1;
    chk("arst_pc",    inst_addr, 32'h0);
    chk("arst_inst",  IF_ID_inst, NOP);
    chk("arst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("arst_scnt",  {16'd0, stall_count}, 32'd0);
    chk("arst_fcnt",  {16'd0, flush_count}, 32'd0);

    pc_write = 1'b1;
    #2 rst = 1'b1;
    step();
    chk("post_pc4",  IF_ID_pc4, 32'h4);
    chk("post_pc",   inst_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
